// File: rtl/arm_fetch_prefetch.sv
// Instruction prefetch stage: fetches words over req/gnt/rvalid, buffers {pc, word}
// in a small FWFT FIFO with a registered head, and flushes on redirect.
module arm_fetch_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [PW-1:0] r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt;
  entry_t        r_mem [DEPTH];
  entry_t        r_head, w_head_nxt, w_new;
  logic          r_valid;
  logic          w_push, w_pop;

  // Flush beats both the pop and the push of the same cycle.
  assign w_pop  = r_valid & instr_ready & ~redirect_valid;
  assign w_push = (r_state == S_WAIT) & imem_rvalid & ~redirect_valid;
  assign w_new  = '{pc: r_fetch_pc, data: imem_rdata};

  always_comb begin
    w_count_nxt = r_count;
    w_wptr_nxt  = r_wptr;
    w_rptr_nxt  = r_rptr;
    if (redirect_valid) begin
      w_count_nxt = '0;
      w_wptr_nxt  = '0;
      w_rptr_nxt  = '0;
    end else begin
      if (w_push) w_wptr_nxt = r_wptr + PW'(1);
      if (w_pop)  w_rptr_nxt = r_rptr + PW'(1);
      if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
      else if (w_pop && !w_push) w_count_nxt = r_count - CW'(1);
    end
  end

  // The next head is either the word being pushed (FIFO empty after the pop)
  // or the stored entry the read pointer moves onto.
  always_comb begin
    w_head_nxt = r_mem[w_rptr_nxt];
    if (w_push && (r_wptr == w_rptr_nxt)) w_head_nxt = w_new;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_count_nxt < FULL) w_state_nxt = S_REQ;
      S_REQ: begin
        if (imem_gnt) w_state_nxt = redirect_valid ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid)   w_state_nxt = imem_rvalid ? S_REQ : S_DROP;
        else if (imem_rvalid) w_state_nxt = (w_count_nxt < FULL) ? S_REQ : S_IDLE;
      end
      S_DROP: if (imem_rvalid) w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_valid    <= 1'b0;
      r_head     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_valid <= (w_count_nxt != '0);
      if (w_push || w_pop) r_head <= w_head_nxt;
      if (redirect_valid)  r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      else if (w_push)     r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= w_new;
    end
  end

  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = r_fetch_pc;
  assign instr_valid = r_valid;
  assign instr_out   = r_head.data;
  assign instr_pc    = r_head.pc;

endmodule

// File: tb/tb_arm_fetch_prefetch.sv
// Bench for arm_fetch_prefetch: directed scenarios plus a randomized run checked
// against an address-derived memory and a "consumed PCs are sequential since the last redirect" model.
module tb_arm_fetch_prefetch;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic        clk, reset_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_out, instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_cmp = 0, n_bad = 0, cyc = 0;

  // memory model state and knobs
  bit          m_pend;
  logic [31:0] m_addr;
  int          m_lat;
  int unsigned gnt_pct;
  int          lat_cfg;
  bit          lat_rand, gnt_en;

  arm_fetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "time limit");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // Called at a negedge: decide the memory inputs for the next edge, then advance.
  task automatic tick();
    logic [31:0] a;
    a           = imem_addr;
    imem_gnt    = imem_req && gnt_en && ($urandom_range(99) < gnt_pct);
    imem_rvalid = m_pend && (m_lat == 0);
    imem_rdata  = imem_rvalid ? mem_word(m_addr) : $urandom;
    @(posedge clk);
    if (imem_rvalid) m_pend = 0;
    else if (m_pend && m_lat > 0) m_lat--;
    if (imem_gnt) begin
      m_pend = 1;
      m_addr = a;
      m_lat  = lat_rand ? int'($urandom_range(3)) : lat_cfg;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic init_inputs();
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    instr_ready = 0; redirect_valid = 0; redirect_pc = 0;
    m_pend = 0; m_lat = 0; m_addr = 0;
    gnt_en = 1; gnt_pct = 100; lat_rand = 0; lat_cfg = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    init_inputs();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    cyc = 0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    init_inputs();
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0)     begin n_bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== RPC)     begin n_bad++; $display("FAIL rst_addr: got %h want %h", imem_addr, RPC); end
    n_cmp++; if (instr_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_cmp++; if (instr_out !== 32'h0)   begin n_bad++; $display("FAIL rst_out: got %h want 0", instr_out); end
    n_cmp++; if (instr_pc !== 32'h0)    begin n_bad++; $display("FAIL rst_pc: got %h want 0", instr_pc); end
    reset_n = 1;
    gnt_en = 0;
    tick();
    n_cmp++; if (imem_req !== 1'b1)     begin n_bad++; $display("FAIL rst_req_cycle2: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== RPC)     begin n_bad++; $display("FAIL rst_addr_cycle2: got %h want %h", imem_addr, RPC); end
  endtask

  task automatic test_seq_fetch();
    logic [31:0] exp_req, exp_pop;
    int npop, last;
    do_reset();
    instr_ready = 1;
    exp_req = RPC; exp_pop = RPC; npop = 0; last = 0;
    for (int i = 0; i < 24; i++) begin
      if (imem_req) begin
        n_cmp++; if (imem_addr !== exp_req) begin n_bad++; $display("FAIL seq_addr: got %h want %h", imem_addr, exp_req); end
        exp_req += 4;
      end
      if (instr_valid) begin
        n_cmp++; if (instr_pc !== exp_pop) begin n_bad++; $display("FAIL seq_pc: got %h want %h", instr_pc, exp_pop); end
        n_cmp++; if (instr_out !== mem_word(exp_pop)) begin n_bad++; $display("FAIL seq_out: got %h want %h", instr_out, mem_word(exp_pop)); end
        if (npop == 0) begin
          n_cmp++; if (cyc != 3) begin n_bad++; $display("FAIL seq_first_latency: got %0d want 3", cyc); end
        end else begin
          n_cmp++; if (cyc - last != 2) begin n_bad++; $display("FAIL seq_rate: got %0d want 2", cyc - last); end
        end
        last = cyc; npop++; exp_pop += 4;
      end
      tick();
    end
    n_cmp++; if (npop != 11) begin n_bad++; $display("FAIL seq_count: got %0d want 11", npop); end
  endtask

  task automatic test_backpressure();
    int ngr;
    do_reset();
    ngr = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) ngr++;
      if (instr_valid) begin
        n_cmp++; if (instr_pc !== RPC) begin n_bad++; $display("FAIL bp_head_stable: got %h want %h", instr_pc, RPC); end
      end
      tick();
    end
    n_cmp++; if (ngr != DEPTH)        begin n_bad++; $display("FAIL bp_fetches: got %0d want %0d", ngr, DEPTH); end
    n_cmp++; if (imem_req !== 1'b0)   begin n_bad++; $display("FAIL bp_req_full: got %b want 0", imem_req); end
    n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b want 1", instr_valid); end
    n_cmp++; if (instr_out !== mem_word(RPC)) begin n_bad++; $display("FAIL bp_out: got %h want %h", instr_out, mem_word(RPC)); end
    instr_ready = 1;
    tick();
    instr_ready = 0;
    n_cmp++; if (imem_req !== 1'b1)        begin n_bad++; $display("FAIL bp_req_after_pop: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== RPC + 32'h10) begin n_bad++; $display("FAIL bp_addr_after_pop: got %h want %h", imem_addr, RPC + 32'h10); end
    n_cmp++; if (instr_pc !== RPC + 32'h4)   begin n_bad++; $display("FAIL bp_next_head: got %h want %h", instr_pc, RPC + 32'h4); end
    n_cmp++; if (instr_out !== mem_word(RPC + 32'h4)) begin n_bad++; $display("FAIL bp_next_out: got %h want %h", instr_out, mem_word(RPC + 32'h4)); end
  endtask

  task automatic test_redirect_wait();
    bit found;
    int guard;
    do_reset();
    instr_ready = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_req && imem_addr == RPC + 32'h4) begin lat_cfg = 3; found = 1; end
      tick();
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL rw_grant104: got none want request at %h", RPC + 32'h4); end
    redirect_valid = 1; redirect_pc = 32'h0000_2002;
    tick();
    redirect_valid = 0; lat_cfg = 0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rw_valid_flush: got %b want 0", instr_valid); end
    n_cmp++; if (imem_req !== 1'b0)    begin n_bad++; $display("FAIL rw_no_req_in_drop: got %b want 0", imem_req); end
    guard = 0;
    while (!imem_req && guard < 20) begin tick(); guard++; end
    n_cmp++; if (imem_req !== 1'b1)        begin n_bad++; $display("FAIL rw_req: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h2000)   begin n_bad++; $display("FAIL rw_addr: got %h want 00002000", imem_addr); end
    n_cmp++; if (m_pend !== 1'b0)          begin n_bad++; $display("FAIL rw_req_before_rvalid: got pending %b want 0", m_pend); end
    guard = 0;
    while (!instr_valid && guard < 20) begin tick(); guard++; end
    n_cmp++; if (instr_pc !== 32'h2000)    begin n_bad++; $display("FAIL rw_first_pc: got %h want 00002000", instr_pc); end
    n_cmp++; if (instr_out !== mem_word(32'h2000)) begin n_bad++; $display("FAIL rw_first_out: got %h want %h", instr_out, mem_word(32'h2000)); end
  endtask

  task automatic test_redirect_rvalid_pop();
    int ngr, guard;
    do_reset();
    ngr = 0;
    for (int i = 0; i < 20 && ngr < 3; i++) begin
      if (imem_req) ngr++;
      tick();
    end
    n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL rrp_pre_valid: got %b want 1", instr_valid); end
    n_cmp++; if (instr_pc !== RPC)     begin n_bad++; $display("FAIL rrp_pre_pc: got %h want %h", instr_pc, RPC); end
    redirect_valid = 1; redirect_pc = 32'h0000_3000; instr_ready = 1;
    tick();
    redirect_valid = 0; instr_ready = 0;
    n_cmp++; if (instr_valid !== 1'b0)   begin n_bad++; $display("FAIL rrp_valid: got %b want 0", instr_valid); end
    n_cmp++; if (imem_req !== 1'b1)      begin n_bad++; $display("FAIL rrp_req: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h3000) begin n_bad++; $display("FAIL rrp_addr: got %h want 00003000", imem_addr); end
    guard = 0;
    while (!instr_valid && guard < 20) begin tick(); guard++; end
    n_cmp++; if (instr_pc !== 32'h3000)  begin n_bad++; $display("FAIL rrp_first_pc: got %h want 00003000", instr_pc); end
    n_cmp++; if (instr_out !== mem_word(32'h3000)) begin n_bad++; $display("FAIL rrp_first_out: got %h want %h", instr_out, mem_word(32'h3000)); end
  endtask

  task automatic test_retarget_wrap();
    int guard, ngr, npop;
    do_reset();
    gnt_en = 0; instr_ready = 1;
    guard = 0;
    while (!imem_req && guard < 10) begin tick(); guard++; end
    n_cmp++; if (imem_addr !== RPC) begin n_bad++; $display("FAIL rt_first_addr: got %h want %h", imem_addr, RPC); end
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 0;
    n_cmp++; if (imem_req !== 1'b1)          begin n_bad++; $display("FAIL rt_req: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL rt_addr: got %h want fffffffc", imem_addr); end
    gnt_en = 1; ngr = 0; npop = 0;
    for (int i = 0; i < 30 && npop < 2; i++) begin
      if (imem_req) begin
        if (ngr == 1) begin
          n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL rt_wrap_addr: got %h want 00000000", imem_addr); end
        end
        ngr++;
      end
      if (instr_valid) begin
        if (npop == 0) begin
          n_cmp++; if (instr_pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL rt_pc0: got %h want fffffffc", instr_pc); end
          n_cmp++; if (instr_out !== mem_word(32'hFFFF_FFFC)) begin n_bad++; $display("FAIL rt_out0: got %h want %h", instr_out, mem_word(32'hFFFF_FFFC)); end
        end else begin
          n_cmp++; if (instr_pc !== 32'h0) begin n_bad++; $display("FAIL rt_pc1: got %h want 00000000", instr_pc); end
        end
        npop++;
      end
      tick();
    end
    n_cmp++; if (npop != 2) begin n_bad++; $display("FAIL rt_pops: got %0d want 2", npop); end
  endtask

  task automatic test_async_reset();
    int guard, nbad_v;
    do_reset();
    guard = 0;
    while (!instr_valid && guard < 20) begin tick(); guard++; end
    lat_cfg = 6;
    guard = 0;
    while (!m_pend && guard < 20) begin tick(); guard++; end
    n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL ar_pre_valid: got %b want 1", instr_valid); end
    imem_gnt = 0; imem_rvalid = 0;
    #2 reset_n = 0;
    #1;
    n_cmp++; if (imem_req !== 1'b0)    begin n_bad++; $display("FAIL ar_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== RPC)    begin n_bad++; $display("FAIL ar_addr: got %h want %h", imem_addr, RPC); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL ar_valid: got %b want 0", instr_valid); end
    n_cmp++; if (instr_out !== 32'h0)  begin n_bad++; $display("FAIL ar_out: got %h want 0", instr_out); end
    n_cmp++; if (instr_pc !== 32'h0)   begin n_bad++; $display("FAIL ar_pc: got %h want 0", instr_pc); end
    @(negedge clk);
    reset_n = 1; gnt_en = 0; instr_ready = 1;
    nbad_v = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (instr_valid !== 1'b0) nbad_v++;
    end
    n_cmp++; if (nbad_v != 0)        begin n_bad++; $display("FAIL ar_stray_push: got %0d valid cycles want 0", nbad_v); end
    n_cmp++; if (imem_addr !== RPC)  begin n_bad++; $display("FAIL ar_addr_after: got %h want %h", imem_addr, RPC); end
    gnt_en = 1; lat_cfg = 0;
    guard = 0;
    while (!instr_valid && guard < 20) begin tick(); guard++; end
    n_cmp++; if (instr_pc !== RPC)   begin n_bad++; $display("FAIL ar_restart_pc: got %h want %h", instr_pc, RPC); end
    n_cmp++; if (instr_out !== mem_word(RPC)) begin n_bad++; $display("FAIL ar_restart_out: got %h want %h", instr_out, mem_word(RPC)); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    int pops;
    bit prev_redir;
    do_reset();
    gnt_pct = 70; lat_rand = 1;
    exp_pc = RPC; pops = 0; prev_redir = 0;
    for (int i = 0; i < 3000; i++) begin
      instr_ready    = ($urandom_range(99) < 60);
      redirect_valid = ($urandom_range(99) < 3);
      redirect_pc    = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      if (prev_redir) begin
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_flush_valid: got %b want 0", instr_valid); end
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (instr_valid && instr_ready) begin
        n_cmp++; if (instr_pc !== exp_pc) begin n_bad++; $display("FAIL rnd_pc: got %h want %h", instr_pc, exp_pc); end
        n_cmp++; if (instr_out !== mem_word(exp_pc)) begin n_bad++; $display("FAIL rnd_out: got %h want %h", instr_out, mem_word(exp_pc)); end
        exp_pc += 4;
        pops++;
      end
      prev_redir = redirect_valid;
      tick();
    end
    redirect_valid = 0; instr_ready = 0;
    n_cmp++; if (pops < 200) begin n_bad++; $display("FAIL rnd_progress: got %0d pops want at least 200", pops); end
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rvalid_pop();
    test_retarget_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
